// File: rtl/spi_frame_sender.sv
// SPI mode-0 frame sender: latches a right-aligned frame of i_len bits and shifts it
// out MSB-first on csb/sclk/mosi with an sclk half-period of CLK_DIV clock cycles.
module spi_frame_sender #(
  parameter int DATA_W  = 80,
  parameter int LEN_W   = 7,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_csb,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic [2:0]        o_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  bits_q, bits_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              csb_q, csb_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;

  logic              len_ok;
  logic              phase_end;
  logic [DATA_W-1:0] aligned;

  // Handshake: i_start is a one-cycle request honoured only in IDLE (including the
  // o_done cycle); every accepted request, null or not, ends with one o_done pulse.
  assign len_ok    = (i_len != '0) && (i_len <= MAX_LEN);
  assign aligned   = i_data << (MAX_LEN - i_len);
  assign phase_end = (div_q == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    csb_d   = csb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    if (state_q != IDLE) begin
      div_d = phase_end ? '0 : div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (i_start) begin
          if (len_ok) begin
            state_d = SETUP;
            shreg_d = aligned;
            bits_d  = i_len;
            busy_d  = 1'b1;
            csb_d   = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = aligned[DATA_W-1];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d = SCK_HI;
          sclk_d  = 1'b1;
        end
      end
      SCK_HI: begin
        // bits_q counts bits not yet fully sent, including the one on mosi now.
        if (phase_end) begin
          state_d = SCK_LO;
          sclk_d  = 1'b0;
          shreg_d = shreg_q << 1;
          bits_d  = bits_q - 1'b1;
          mosi_d  = (bits_q != LEN_W'(1)) ? shreg_q[DATA_W-2] : 1'b0;
        end
      end
      SCK_LO: begin
        if (phase_end) begin
          if (bits_q != '0) begin
            state_d = SCK_HI;
            sclk_d  = 1'b1;
          end else begin
            state_d = GAP;
            csb_d   = 1'b1;
            mosi_d  = 1'b0;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_csb   = csb_q;
  assign o_sclk  = sclk_q;
  assign o_mosi  = mosi_q;
  assign o_state = state_q;

endmodule

// File: doc/spi_frame_sender.md
Name: spi_frame_sender

Overview:
- SPI mode-0 master that drives the 3-wire register/vector load port of the raycaster core (csb/sclk/mosi, slave samples on sclk rising edge).
- Takes a right-aligned parallel frame and its bit length, then shifts it out MSB-first with programmable sclk rate.
- Gives on-chip logic (LA/Wishbone bridge, self-test sequencer) a way to load registers without bit-banging LA pins.

Parameters:
- DATA_W, 80, maximum frame length in bits (width of i_data).
- LEN_W, 7, width of i_len; must satisfy 2^LEN_W > DATA_W.
- CLK_DIV, 2, sclk half-period in i_clk cycles (D); legal range >= 1.

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle request; sampled only when idle.
- i_data  input  DATA_W  frame bits, right-aligned; i_data[i_len-1] is sent first.
- i_len  input  LEN_W  number of bits N to send.
- o_busy  output  1  high from the cycle after an accepted start until frame end.
- o_done  output  1  one-cycle pulse at frame completion (also for null frames).
- o_csb  output  1  SPI chip select, active low.
- o_sclk  output  1  SPI clock, idles low.
- o_mosi  output  1  SPI data out.

Behaviour:
- Clock/reset:
  - Single clock domain.
  - i_reset_n low, asynchronously: o_csb=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, FSM=IDLE, counters=0.
  - Reset mid-frame aborts the frame immediately; o_done is not pulsed.
- Start acceptance:
  - i_start is accepted in cycle T when FSM=IDLE.
  - i_data and i_len are latched into a shift register and a bit counter at T; later input changes have no effect on the frame.
  - i_start while busy is ignored; nothing is queued.
- Null frame: if i_len==0 or i_len>DATA_W, no SPI activity occurs; o_done pulses at T+1 and o_busy stays 0.
- FSM states: IDLE -> SETUP -> SCK_HI -> SCK_LO -> (SCK_HI | GAP) -> IDLE. A divider counter runs 0..D-1 in each timed state.
  - SETUP (D cycles, from T+1): o_csb=0, o_sclk=0, o_mosi=first bit, o_busy=1.
  - SCK_HI (D cycles): o_sclk=1; o_mosi is held stable.
  - SCK_LO (D cycles): o_sclk=0.
    - On entry, o_mosi shifts to the next bit; after the last bit, o_mosi goes to 0.
    - If bits remain, go to SCK_HI; otherwise go to GAP.
    - The SCK_LO phase of the last bit serves as csb hold time.
  - GAP (D cycles): o_csb=1, o_sclk=0, o_mosi=0; o_busy stays 1.
  - Exit to IDLE: o_done=1 and o_busy=0 in cycle T+1+(2N+2)D.
  - A new i_start is accepted in that same cycle, so the next frame begins SETUP at T+2+(2N+2)D.
- Timing:
  - Rising edge of bit k (k=0..N-1) occurs at cycle T+1+D+2kD.
  - o_csb is low for exactly D+2ND cycles.
  - The sclk rising-edge count per frame equals N exactly.
  - o_sclk is never high while o_csb=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, no start -> o_csb=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0 for 100 cycles; asserting reset mid-idle changes nothing.
- D=2, N=8, i_data=8'hA5, start at T:
  - o_csb low T+1..T+34.
  - 8 sclk rises at T+3, T+7, ..., T+31.
  - Bits captured on the rises = 1,0,1,0,0,1,0,1.
  - o_csb high T+35..T+36; o_done pulse at T+37.
- D=1, N=80, alternating pattern 0xAAAA... with i_data changed after T -> slave model captures the original latched 80 bits; o_done at T+163; exactly 80 rises.
- Null frames: N=0, then N=81 -> no csb/sclk activity; o_done at T+1 each; o_busy stays 0.
- Start pulsed repeatedly during a frame, then back-to-back start on the o_done cycle -> mid-frame starts ignored; second frame's csb falls at done_cycle+1 with correct data.
- i_reset_n low at bit 3 of a 16-bit frame -> o_csb=1 and o_sclk=0 asynchronously in the same cycle; no o_done; next start transmits the full frame correctly.
